// File: rtl/convolution_3x3.sv
// 3x3 convolution over an RGB565 column stream.
// A 3-column window feeds a 4-stage per-channel MAC pipeline; the output is the
// window centre, filtered by the selected kernel or passed through on the frame border.
module convolution_3x3 #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [1:0]       kernel_select_in,
  input  logic [2:0][15:0] line_buffer_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             data_valid_in,
  output logic [15:0]      pixel_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             data_valid_out
);

  localparam logic [10:0] HLast = 11'(WIDTH - 1);
  localparam logic [9:0]  VLast = 10'(HEIGHT - 1);

  typedef enum logic [1:0] {
    KIdentity = 2'd0,
    KGaussian = 2'd1,
    KSharpen  = 2'd2,
    KEdge     = 2'd3
  } kernel_e;

  // Channel ch of an RGB565 pixel, zero-extended into the accumulator width.
  function automatic logic signed [11:0] chan(input logic [15:0] pix, input logic [1:0] ch);
    logic signed [11:0] res;
    res = '0;
    unique case (ch)
      2'd0:    res = $signed({7'd0, pix[15:11]});
      2'd1:    res = $signed({6'd0, pix[10:5]});
      default: res = $signed({7'd0, pix[4:0]});
    endcase
    return res;
  endfunction

  // Weighted sum of one kernel row; a/c are the outer columns, b the middle one.
  // Every kernel is left/right symmetric, so only the outer sum matters.
  function automatic logic signed [11:0] row_sum(input kernel_e k, input logic centre_row,
                                                 input logic signed [11:0] a,
                                                 input logic signed [11:0] b,
                                                 input logic signed [11:0] c);
    logic signed [11:0] outer;
    logic signed [11:0] res;
    outer = a + c;
    res   = '0;
    unique case (k)
      KIdentity: res = centre_row ? b : 12'sd0;
      KGaussian: res = centre_row ? (outer <<< 1) + (b <<< 2) : outer + (b <<< 1);
      KSharpen:  res = centre_row ? (b <<< 2) + b - outer : -b;
      default:   res = centre_row ? (b <<< 3) - outer : -(outer + b);
    endcase
    return res;
  endfunction

  function automatic logic [4:0] clamp5(input logic signed [11:0] v);
    logic [4:0] res;
    if (v[11])                res = '0;
    else if (v[10:0] > 11'd31) res = 5'd31;
    else                      res = v[4:0];
    return res;
  endfunction

  function automatic logic [5:0] clamp6(input logic signed [11:0] v);
    logic [5:0] res;
    if (v[11])                res = '0;
    else if (v[10:0] > 11'd63) res = 6'd63;
    else                      res = v[5:0];
    return res;
  endfunction

  // Window: [0] newest column, [1] centre, [2] oldest; each column indexed by row.
  logic [2:0][2:0][15:0] win_q;
  logic [1:0][10:0]      win_h_q;
  logic [1:0][9:0]       win_v_q;
  kernel_e               win_kernel_q;
  logic                  win_valid_q;
  logic                  primed_q;

  // S1 snapshot of the window for the centre being computed.
  logic [2:0][2:0][15:0] s1_win_q;
  logic [10:0]           s1_h_q;
  logic [9:0]            s1_v_q;
  kernel_e               s1_kernel_q;
  logic                  s1_border_q;
  logic                  s1_valid_q;
  logic                  border_d;

  // S2 per-row sums, indexed [channel][row].
  logic signed [11:0]    row_d [3][3];
  logic signed [11:0]    row_q [3][3];
  logic [15:0]           s2_centre_q;
  logic [10:0]           s2_h_q;
  logic [9:0]            s2_v_q;
  kernel_e               s2_kernel_q;
  logic                  s2_border_q;
  logic                  s2_valid_q;

  // S3 per-channel totals after the kernel shift.
  logic signed [11:0]    total_d [3];
  logic signed [11:0]    total_q [3];
  logic [15:0]           s3_centre_q;
  logic [10:0]           s3_h_q;
  logic [9:0]            s3_v_q;
  logic                  s3_border_q;
  logic                  s3_valid_q;

  logic [15:0]           pixel_d;

  // Window shift and tag capture on every accepted beat; the first beat after reset is
  // only used to fill the window, so it never produces an output.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      win_q        <= '0;
      win_h_q      <= '0;
      win_v_q      <= '0;
      win_kernel_q <= KIdentity;
      win_valid_q  <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      win_valid_q <= data_valid_in & primed_q;
      if (data_valid_in) begin
        win_q        <= {win_q[1:0], line_buffer_in};
        win_h_q      <= {win_h_q[0], hcount_in};
        win_v_q      <= {win_v_q[0], vcount_in};
        win_kernel_q <= kernel_e'(kernel_select_in);
        primed_q     <= 1'b1;
      end
    end
  end

  // Border detect on the centre tags.
  always_comb begin
    border_d = (win_h_q[1] == '0) || (win_h_q[1] == HLast) ||
               (win_v_q[1] == '0) || (win_v_q[1] == VLast);
  end

  // S1 snapshot: freezes the window so later beats cannot disturb an in-flight pixel.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_win_q    <= '0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      s1_kernel_q <= KIdentity;
      s1_border_q <= 1'b0;
      s1_valid_q  <= 1'b0;
    end else begin
      s1_valid_q <= win_valid_q;
      if (win_valid_q) begin
        s1_win_q    <= win_q;
        s1_h_q      <= win_h_q[1];
        s1_v_q      <= win_v_q[1];
        s1_kernel_q <= win_kernel_q;
        s1_border_q <= border_d;
      end
    end
  end

  // Row sums per channel.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      for (int r = 0; r < 3; r++) begin
        row_d[ch][r] = row_sum(s1_kernel_q, r == 1,
                               chan(s1_win_q[2][r], 2'(ch)),
                               chan(s1_win_q[1][r], 2'(ch)),
                               chan(s1_win_q[0][r], 2'(ch)));
      end
    end
  end

  // S2 registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      row_q       <= '{default: '0};
      s2_centre_q <= '0;
      s2_h_q      <= '0;
      s2_v_q      <= '0;
      s2_kernel_q <= KIdentity;
      s2_border_q <= 1'b0;
      s2_valid_q  <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        row_q       <= row_d;
        s2_centre_q <= s1_win_q[1][1];
        s2_h_q      <= s1_h_q;
        s2_v_q      <= s1_v_q;
        s2_kernel_q <= s1_kernel_q;
        s2_border_q <= s1_border_q;
      end
    end
  end

  // Channel totals; only the Gaussian kernel needs normalising.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      total_d[ch] = row_q[ch][0] + row_q[ch][1] + row_q[ch][2];
      if (s2_kernel_q == KGaussian) begin
        total_d[ch] = total_d[ch] >>> 4;
      end
    end
  end

  // S3 registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      total_q     <= '{default: '0};
      s3_centre_q <= '0;
      s3_h_q      <= '0;
      s3_v_q      <= '0;
      s3_border_q <= 1'b0;
      s3_valid_q  <= 1'b0;
    end else begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        total_q     <= total_d;
        s3_centre_q <= s2_centre_q;
        s3_h_q      <= s2_h_q;
        s3_v_q      <= s2_v_q;
        s3_border_q <= s2_border_q;
      end
    end
  end

  // Clamp, repack and border pass-through.
  always_comb begin
    pixel_d = {clamp5(total_q[0]), clamp6(total_q[1]), clamp5(total_q[2])};
    if (s3_border_q) begin
      pixel_d = s3_centre_q;
    end
  end

  // S4 output registers; data outputs hold between valid pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pixel_out      <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= s3_valid_q;
      if (s3_valid_q) begin
        pixel_out  <= pixel_d;
        hcount_out <= s3_h_q;
        vcount_out <= s3_v_q;
      end
    end
  end

endmodule
